// File: rtl/x86_bus_arbiter.sv
// Two-requester memory bus arbiter: data port has priority, prefetch is guaranteed
// a slot after FETCH_SLOT consecutive data grants, and a watchdog aborts stuck cycles.
module x86_bus_arbiter #(
    parameter int FETCH_SLOT  = 4,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ack,
    output logic [31:0] fetch_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic [31:0] o_address,
    output logic [31:0] o_data,
    output logic        o_we,
    output logic        o_req,
    input  logic [31:0] i_data,
    input  logic        i_ready,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam logic [3:0] SLOT     = 4'(FETCH_SLOT);
    localparam logic [7:0] TMO_LAST = 8'(BUS_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        owner_fetch, owner_fetch_nxt;
    logic [3:0]  run, run_nxt;
    logic [7:0]  wd, wd_nxt;
    logic [31:0] address_nxt, odata_nxt, frdata_nxt, drdata_nxt;
    logic        we_nxt, req_nxt, fack_nxt, dack_nxt, err_nxt;
    logic        grant_fetch, finish, timeout;
    logic [31:0] rdata_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            owner_fetch <= 1'b0;
            run         <= '0;
            wd          <= '0;
            o_address   <= '0;
            o_data      <= '0;
            o_we        <= 1'b0;
            o_req       <= 1'b0;
            fetch_ack   <= 1'b0;
            data_ack    <= 1'b0;
            fetch_rdata <= '0;
            data_rdata  <= '0;
            bus_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner_fetch <= owner_fetch_nxt;
            run         <= run_nxt;
            wd          <= wd_nxt;
            o_address   <= address_nxt;
            o_data      <= odata_nxt;
            o_we        <= we_nxt;
            o_req       <= req_nxt;
            fetch_ack   <= fack_nxt;
            data_ack    <= dack_nxt;
            fetch_rdata <= frdata_nxt;
            data_rdata  <= drdata_nxt;
            bus_err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        owner_fetch_nxt = owner_fetch;
        run_nxt         = run;
        wd_nxt          = wd;
        address_nxt     = o_address;
        odata_nxt       = o_data;
        we_nxt          = o_we;
        req_nxt         = o_req;
        fack_nxt        = 1'b0;
        dack_nxt        = 1'b0;
        frdata_nxt      = fetch_rdata;
        drdata_nxt      = data_rdata;
        err_nxt         = bus_err;
        grant_fetch     = fetch_req && (!data_req || run == SLOT);
        timeout         = !i_ready && (wd == TMO_LAST);
        finish          = i_ready || timeout;
        rdata_in        = timeout ? 32'hFFFF_FFFF : i_data;

        case (state)
            IDLE: begin
                if (!fetch_req) begin
                    run_nxt = '0;
                end
                if (fetch_req || data_req) begin
                    owner_fetch_nxt = grant_fetch;
                    req_nxt         = 1'b1;
                    wd_nxt          = '0;
                    state_nxt       = BUS;
                    if (grant_fetch) begin
                        address_nxt = fetch_addr;
                        we_nxt      = 1'b0;
                        run_nxt     = '0;
                    end else begin
                        address_nxt = data_addr;
                        we_nxt      = data_we;
                        if (data_we) begin
                            odata_nxt = data_wdata;
                        end
                        // Count data wins only while fetch is actually being held off.
                        if (fetch_req && run != SLOT) begin
                            run_nxt = run + 4'd1;
                        end
                    end
                end
            end
            BUS: begin
                if (finish) begin
                    if (owner_fetch) begin
                        fack_nxt   = 1'b1;
                        frdata_nxt = rdata_in;
                    end else begin
                        dack_nxt = 1'b1;
                        if (!o_we) begin
                            drdata_nxt = rdata_in;
                        end
                    end
                    err_nxt   = bus_err | timeout;
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    state_nxt = DONE;
                end else begin
                    wd_nxt = wd + 8'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
